// File: rtl/inst_encoder_pkg.sv
// inst_encoder_pkg
//   Shared types and constants for the instruction encoder/loader.
//   - fmt_e   : instruction format selector (I, S, B, R)
//   - state_e : loader FSM states
//   - OP_*    : RV32 major opcodes for the supported formats
//   - imm_fits: true when a 32-bit value sign-extends from bit 'msb'
package inst_encoder_pkg;

   typedef enum logic [1:0] {
      FMT_I = 2'd0,
      FMT_S = 2'd1,
      FMT_B = 2'd2,
      FMT_R = 2'd3
   } fmt_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] OP     = 7'b0110011;

   // All bits from 31 down to msb must match, i.e. the value is the sign
   // extension of its low (msb+1) bits.
   function automatic logic imm_fits(input logic [31:0] imm, input int msb);
      logic all_ones;
      logic all_zeros;
      all_ones  = 1'b1;
      all_zeros = 1'b1;
      for (int i = 0; i < 32; i++) begin
         if (i >= msb) begin
            all_ones  = all_ones & imm[i];
            all_zeros = all_zeros & ~imm[i];
         end
      end
      return all_ones | all_zeros;
   endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// inst_pack
//   Combinational packer: assembles the RV32 instruction word from decoded
//   fields and flags whether the request is encodable.
//   Optional feature macro: INST_ENCODER_RTYPE_EN (adds funct7 / R-format).
//   Ports:
//     fmt, opcode, funct3, rd, rs1, rs2, imm  - decoded fields
//     funct7                                  - R-format only (macro)
//     word                                    - packed instruction
//     legal                                   - immediate in range / format allowed
import inst_encoder_pkg::*;

module inst_pack (
   input  fmt_e        fmt,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
`ifdef INST_ENCODER_RTYPE_EN
   input  logic [6:0]  funct7,
`endif
   output logic [31:0] word,
   output logic        legal
);

   always_comb begin
      word  = 32'd0;
      legal = 1'b0;
      case (fmt)
         FMT_I: begin
            word  = {imm[11:0], rs1, funct3, rd, opcode};
            legal = imm_fits(imm, 11);
         end
         FMT_S: begin
            word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            legal = imm_fits(imm, 11);
         end
         FMT_B: begin
            // Branch offsets are halfword multiples; bit 0 is not encoded.
            word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            legal = imm_fits(imm, 12) & ~imm[0];
         end
         FMT_R: begin
`ifdef INST_ENCODER_RTYPE_EN
            word  = {funct7, rs2, rs1, funct3, rd, opcode};
            legal = 1'b1;
`else
            word  = 32'd0;
            legal = 1'b0;
`endif
         end
         default: begin
            word  = 32'd0;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder
//   Instruction encoder/loader. Packs decoded fields into RV32 words and
//   writes them sequentially into instruction memory starting at BASE_ADDR.
//   Optional feature macro: INST_ENCODER_RTYPE_EN (adds funct7_i, R-format).
//   Ports:
//     clk_i, rst_i        - clock, async active-high reset
//     clear_i             - synchronous restart of address/count/error
//     valid_i / ready_o   - request handshake
//     fmt_i .. imm_i      - decoded instruction fields
//     funct7_i            - R-format funct7 (macro only)
//     mem_we_o/addr/data  - memory write, held until mem_ready_i
//     count_o, full_o     - words written, image full
//     err_o               - sticky range/format error
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | ready for a request; illegal requests only set err_o
//   ST_WRITE | write strobe asserted, waiting for mem_ready_i
//   ST_FULL  | 2^ADDR_W words written; requests ignored until clear/reset
import inst_encoder_pkg::*;

module inst_encoder #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clear_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic [1:0]          fmt_i,
   input  logic [6:0]          opcode_i,
   input  logic [2:0]          funct3_i,
   input  logic [4:0]          rd_i,
   input  logic [4:0]          rs1_i,
   input  logic [4:0]          rs2_i,
   input  logic [31:0]         imm_i,
`ifdef INST_ENCODER_RTYPE_EN
   input  logic [6:0]          funct7_i,
`endif
   output logic                mem_we_o,
   output logic [ADDR_W+1:0]   mem_addr_o,
   output logic [31:0]         mem_data_o,
   input  logic                mem_ready_i,
   output logic [ADDR_W:0]     count_o,
   output logic                full_o,
   output logic                err_o
);

   localparam logic [ADDR_W+1:0] BASE_A     = (ADDR_W+2)'(BASE_ADDR);
   localparam logic [ADDR_W+1:0] ADDR_STEP  = (ADDR_W+2)'(4);
   localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

   state_e          state;
   logic [31:0]     pack_word;
   logic            pack_legal;
   logic [ADDR_W:0] count_nxt;

   inst_pack u_pack (
      .fmt    (fmt_e'(fmt_i)),
      .opcode (opcode_i),
      .funct3 (funct3_i),
      .rd     (rd_i),
      .rs1    (rs1_i),
      .rs2    (rs2_i),
      .imm    (imm_i),
`ifdef INST_ENCODER_RTYPE_EN
      .funct7 (funct7_i),
`endif
      .word   (pack_word),
      .legal  (pack_legal)
   );

   assign count_nxt = count_o + 1'b1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         ready_o    <= 1'b1;
         mem_we_o   <= 1'b0;
         mem_addr_o <= BASE_A;
         mem_data_o <= 32'd0;
         count_o    <= '0;
         full_o     <= 1'b0;
         err_o      <= 1'b0;
      end else if (clear_i) begin
         // Drops any pending write; mem_data_o keeps its last value.
         state      <= ST_IDLE;
         ready_o    <= 1'b1;
         mem_we_o   <= 1'b0;
         mem_addr_o <= BASE_A;
         count_o    <= '0;
         full_o     <= 1'b0;
         err_o      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (valid_i) begin
                  if (pack_legal) begin
                     mem_data_o <= pack_word;
                     mem_we_o   <= 1'b1;
                     ready_o    <= 1'b0;
                     state      <= ST_WRITE;
                  end else begin
                     err_o <= 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               if (mem_ready_i) begin
                  mem_we_o   <= 1'b0;
                  mem_addr_o <= mem_addr_o + ADDR_STEP;
                  count_o    <= count_nxt;
                  if (count_nxt == FULL_COUNT) begin
                     full_o <= 1'b1;
                     state  <= ST_FULL;
                  end else begin
                     ready_o <= 1'b1;
                     state   <= ST_IDLE;
                  end
               end
            end
            ST_FULL: begin
               ready_o <= 1'b0;
            end
            default: begin
               state    <= ST_IDLE;
               ready_o  <= 1'b1;
               mem_we_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

   localparam int AW    = 2;
   localparam int DEPTH = 1 << AW;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            clear = 1'b0;
   logic            valid = 1'b0;
   logic            ready;
   logic [1:0]      fmt = '0;
   logic [6:0]      opcode = '0;
   logic [2:0]      funct3 = '0;
   logic [4:0]      rd = '0, rs1 = '0, rs2 = '0;
   logic [31:0]     imm = '0;
   logic [6:0]      funct7 = '0;
   logic            mem_we;
   logic [AW+1:0]   mem_addr;
   logic [31:0]     mem_data;
   logic            mem_ready = 1'b1;
   logic [AW:0]     count;
   logic            full;
   logic            err;

   int checks = 0;
   int errors = 0;
   int m_count = 0;
   bit m_err = 0;

   typedef struct {
      logic [1:0]  fmt;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] word;
      bit          legal;
   } vec_t;

   vec_t vecs[10];

   inst_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .clear_i     (clear),
      .valid_i     (valid),
      .ready_o     (ready),
      .fmt_i       (fmt),
      .opcode_i    (opcode),
      .funct3_i    (funct3),
      .rd_i        (rd),
      .rs1_i       (rs1),
      .rs2_i       (rs2),
      .imm_i       (imm),
`ifdef INST_ENCODER_RTYPE_EN
      .funct7_i    (funct7),
`endif
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_data_o  (mem_data),
      .mem_ready_i (mem_ready),
      .count_o     (count),
      .full_o      (full),
      .err_o       (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference encoder: fields placed by arithmetic shifts of the immediate,
   // legality by signed range of the immediate value.
   function automatic void model(inout vec_t v);
      int          si;
      logic [31:0] base;
      si   = $signed(v.imm);
      base = (32'(v.rs1) << 15) | (32'(v.f3) << 12) | 32'(v.op);
      case (v.fmt)
         2'd0: begin
            v.word  = ((v.imm & 32'hFFF) << 20) | base | (32'(v.rd) << 7);
            v.legal = (si >= -2048) && (si <= 2047);
         end
         2'd1: begin
            v.word  = (((v.imm >> 5) & 32'h7F) << 25) | (32'(v.rs2) << 20) | base
                      | ((v.imm & 32'h1F) << 7);
            v.legal = (si >= -2048) && (si <= 2047);
         end
         2'd2: begin
            v.word  = (((v.imm >> 12) & 32'h1) << 31) | (((v.imm >> 5) & 32'h3F) << 25)
                      | (32'(v.rs2) << 20) | base | (((v.imm >> 1) & 32'hF) << 8)
                      | (((v.imm >> 11) & 32'h1) << 7);
            v.legal = (si >= -4096) && (si <= 4095) && (si % 2 == 0);
         end
         default: begin
            v.word  = (32'(v.f7) << 25) | (32'(v.rs2) << 20) | base | (32'(v.rd) << 7);
`ifdef INST_ENCODER_RTYPE_EN
            v.legal = 1'b1;
`else
            v.legal = 1'b0;
`endif
         end
      endcase
   endfunction

   task automatic drive(input vec_t v);
      fmt    = v.fmt;
      opcode = v.op;
      funct3 = v.f3;
      rd     = v.rd;
      rs1    = v.rs1;
      rs2    = v.rs2;
      funct7 = v.f7;
      imm    = v.imm;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      m_count = 0;
      m_err   = 0;
      chk("clr_count", 32'(count), 32'd0);
      chk("clr_addr", 32'(mem_addr), 32'd0);
      chk("clr_ready", 32'(ready), 32'd1);
      chk("clr_err", 32'(err), 32'd0);
      chk("clr_full", 32'(full), 32'd0);
      chk("clr_we", 32'(mem_we), 32'd0);
   endtask

   task automatic full_then_clear();
      chk("full_flag", 32'(full), 32'd1);
      chk("full_ready", 32'(ready), 32'd0);
      fmt = 2'd0; imm = 32'd1;
      valid = 1'b1;
      tick();
      tick();
      valid = 1'b0;
      chk("full_no_we", 32'(mem_we), 32'd0);
      chk("full_count", 32'(count), 32'(DEPTH));
      do_clear();
   endtask

   task automatic do_req(input vec_t v, input string tag);
      if (m_count == DEPTH) full_then_clear();
      drive(v);
      mem_ready = 1'b1;
      chk({tag, "_ready_in"}, 32'(ready), 32'd1);
      valid = 1'b1;
      tick();
      valid = 1'b0;
      if (v.legal) begin
         chk({tag, "_we"}, 32'(mem_we), 32'd1);
         chk({tag, "_data"}, mem_data, v.word);
         chk({tag, "_addr"}, 32'(mem_addr), 32'(m_count * 4));
         tick();
         m_count++;
         chk({tag, "_we_done"}, 32'(mem_we), 32'd0);
         chk({tag, "_count"}, 32'(count), 32'(m_count));
         chk({tag, "_full"}, 32'(full), 32'(m_count == DEPTH));
         chk({tag, "_ready_out"}, 32'(ready), 32'(m_count != DEPTH));
         chk({tag, "_err"}, 32'(err), 32'(m_err));
      end else begin
         m_err = 1;
         chk({tag, "_ill_we"}, 32'(mem_we), 32'd0);
         chk({tag, "_ill_err"}, 32'(err), 32'd1);
         chk({tag, "_ill_count"}, 32'(count), 32'(m_count));
         chk({tag, "_ill_ready"}, 32'(ready), 32'd1);
      end
   endtask

   initial begin
      vec_t v;

      // fmt op f3 rd rs1 rs2 f7 imm word legal
      vecs[0] = '{2'd0, 7'h13, 3'd0, 5'd5, 5'd1, 5'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF08293, 1'b1};
      vecs[1] = '{2'd1, 7'h23, 3'd2, 5'd0, 5'd3, 5'd2, 7'd0, 32'h00000008, 32'h0021A423, 1'b1};
      vecs[2] = '{2'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 7'd0, 32'hFFFFFFFC, 32'hFE208EE3, 1'b1};
      vecs[3] = '{2'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 7'd0, 32'h00000800, 32'h0, 1'b0};
      vecs[4] = '{2'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 7'd0, 32'h00000003, 32'h0, 1'b0};
      vecs[5] = '{2'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 7'd0, 32'h00000005, 32'h00500093, 1'b1};
      vecs[6] = '{2'd0, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, 7'd0, 32'h000007FF, 32'h7FF00013, 1'b1};
      vecs[7] = '{2'd0, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFF800, 32'h80000013, 1'b1};
      vecs[8] = '{2'd1, 7'h23, 3'd2, 5'd0, 5'd3, 5'd2, 7'd0, 32'hFFFFF7FF, 32'h0, 1'b0};
`ifdef INST_ENCODER_RTYPE_EN
      vecs[9] = '{2'd3, 7'h33, 3'd0, 5'd3, 5'd1, 5'd2, 7'd0, 32'h0, 32'h002081B3, 1'b1};
`else
      vecs[9] = '{2'd3, 7'h33, 3'd0, 5'd3, 5'd1, 5'd2, 7'd0, 32'h0, 32'h002081B3, 1'b0};
`endif

      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_data", mem_data, 32'd0);
      rst = 1'b0;
      tick();
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_err", 32'(err), 32'd0);

      for (int i = 0; i < 10; i++) do_req(vecs[i], $sformatf("vec%0d", i));

      // backpressure: three stalled cycles, then one write
      do_clear();
      mem_ready = 1'b0;
      drive(vecs[1]);
      valid = 1'b1;
      tick();
      valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("bp_we", 32'(mem_we), 32'd1);
         chk("bp_addr", 32'(mem_addr), 32'd0);
         chk("bp_data", mem_data, 32'h0021A423);
         chk("bp_ready", 32'(ready), 32'd0);
         tick();
      end
      mem_ready = 1'b1;
      tick();
      m_count = 1;
      chk("bp_we_done", 32'(mem_we), 32'd0);
      chk("bp_count", 32'(count), 32'd1);
      chk("bp_addr_next", 32'(mem_addr), 32'd4);

      // clear drops a pending write
      mem_ready = 1'b0;
      drive(vecs[0]);
      valid = 1'b1;
      tick();
      valid = 1'b0;
      chk("cw_we", 32'(mem_we), 32'd1);
      do_clear();
      mem_ready = 1'b1;

      for (int i = 0; i < 80; i++) begin
         v.fmt = 2'($urandom_range(0, 3));
         v.op  = 7'($urandom);
         v.f3  = 3'($urandom);
         v.rd  = 5'($urandom);
         v.rs1 = 5'($urandom);
         v.rs2 = 5'($urandom);
         v.f7  = 7'($urandom);
         v.imm = $urandom;
         if ($urandom_range(0, 3) != 0) v.imm = {{19{v.imm[12]}}, v.imm[12:0]};
         model(v);
         do_req(v, "rnd");
      end

      // reset during a stalled write
      if (m_count == DEPTH) do_clear();
      mem_ready = 1'b0;
      drive(vecs[2]);
      valid = 1'b1;
      tick();
      valid = 1'b0;
      chk("rw_we", 32'(mem_we), 32'd1);
      rst = 1'b1;
      #1;
      chk("rw_we_rst", 32'(mem_we), 32'd0);
      chk("rw_addr_rst", 32'(mem_addr), 32'd0);
      chk("rw_data_rst", mem_data, 32'd0);
      chk("rw_count_rst", 32'(count), 32'd0);
      chk("rw_ready_rst", 32'(ready), 32'd1);
      chk("rw_err_rst", 32'(err), 32'd0);
      chk("rw_full_rst", 32'(full), 32'd0);
      #1;
      rst = 1'b0;
      mem_ready = 1'b1;
      m_count = 0;
      m_err   = 0;
      tick();

      // fill to capacity and verify the full/clear behaviour
      for (int i = 0; i < DEPTH; i++) do_req(vecs[5], "fill");
      full_then_clear();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
